sign_drain: RTL and testbench

Read-out engine at the output end of the bundling datapath. Each `counter` instance owns one hypervector dimension and exposes only its accumulator sign bit. `sign_drain` waits for the accumulator pipeline to settle, snapshots all `DIM` sign bits, and pulses a clear to the counter bank. It then streams the snapshot as 32-bit words over a valid/ready interface toward the DMA/ACP write path.

---
 rtl/sign_drain.sv | 110 +++++++++++
 tb/tb_sign_drain.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sign_drain.sv
// Sign-bit read-out engine: waits for the counter bank to settle, snapshots all
// sign bits, clears the bank, then streams the packed snapshot as 32-bit words.
module sign_drain #(
    parameter int DIM    = 1024,
    parameter int SETTLE = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DIM-1:0]  sign_bits,
    output logic            clear_req,
    output logic            busy,
    output logic [31:0]     m_data,
    output logic            m_valid,
    output logic            m_last,
    input  logic            m_ready,
    output logic            done
);

    localparam int NW = DIM / 32;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW = 4;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NW - 1);
    localparam logic [CW-1:0] SETTLE_M1 = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [DIM-1:0]  snap_reg;
    logic [31:0]     words [NW];

    // Snapshot is stored already inverted, so a tie (sign 0) reads out as 1.
    for (genvar gi = 0; gi < NW; gi++) begin : g_words
        assign words[gi] = snap_reg[gi*32 +: 32];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (SETTLE == 0) begin
                        state_next = S_CAPTURE;
                    end else begin
                        state_next = S_SETTLE;
                        cnt_next   = SETTLE_M1;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = S_CAPTURE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_CAPTURE: begin
                idx_next   = '0;
                state_next = S_SEND;
            end
            S_SEND: begin
                if (m_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == S_CAPTURE) begin
            snap_reg <= ~sign_bits;
        end
    end

    assign clear_req = (state_reg == S_CAPTURE);
    assign busy      = (state_reg != S_IDLE);
    assign m_valid   = (state_reg == S_SEND);
    assign m_last    = m_valid && (idx_reg == LAST_IDX);
    assign m_data    = m_valid ? words[idx_reg] : 32'h0;
    assign done      = (state_reg == S_DONE);

endmodule

// File: tb/tb_sign_drain.sv
// Directed bench for sign_drain (DIM=64, SETTLE=3) with a word scoreboard.
module tb_sign_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] sign_bits;
    logic        clear_req;
    logic        busy;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        done;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          n_clear  = 0;
    int          n_hs     = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    sign_drain #(.DIM(64), .SETTLE(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign_bits (sign_bits),
        .clear_req (clear_req),
        .busy      (busy),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [63:0] sb);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.data = ~sb[k*32 +: 32];
            e.last = (k == 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (m_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (m_valid !== 1'b1) chk({tag, "_timeout"}, {31'b0, m_valid}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (done !== 1'b1) chk({tag, "_timeout"}, {31'b0, done}, 32'd1);
    endtask

    // Monitor: scoreboard pops on handshakes, stability under stall, pulse counts.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (prev_stall) begin
                chk("stall_valid", {31'b0, m_valid}, 32'd1);
                chk("stall_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                n_hs++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", m_data, 32'hxxxxxxxx);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("word_data", m_data, e.data);
                    chk("word_last", {31'b0, m_last}, {31'b0, e.last});
                end
            end
            if (done)      n_done++;
            if (clear_req) n_clear++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        logic [63:0] a;
        int d0, c0, h0;

        rst = 1'b1; start = 1'b0; sign_bits = '0; m_ready = 1'b1;
        tick(); tick(); tick();
        chk("rst_clear_req", {31'b0, clear_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_last", {31'b0, m_last}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        rst = 1'b0;
        tick();

        // 1: basic timing with all-zero signs
        push_vec(64'h0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy_t1", {31'b0, busy}, 32'd1);
        chk("t1_clear_early", {31'b0, clear_req}, 32'd0);
        tick(); tick(); tick();
        chk("t1_clear_req", {31'b0, clear_req}, 32'd1);
        chk("t1_valid_early", {31'b0, m_valid}, 32'd0);
        tick();
        chk("t1_valid_w0", {31'b0, m_valid}, 32'd1);
        chk("t1_last_w0", {31'b0, m_last}, 32'd0);
        tick();
        chk("t1_last_w1", {31'b0, m_last}, 32'd1);
        tick();
        chk("t1_done", {31'b0, done}, 32'd1);
        chk("t1_valid_off", {31'b0, m_valid}, 32'd0);
        tick();
        chk("t1_busy_low", {31'b0, busy}, 32'd0);
        chk("t1_done_low", {31'b0, done}, 32'd0);

        // 2: packing
        sign_bits = 64'h0000_0001_8000_0000;
        push_vec(sign_bits);
        start = 1'b1; tick(); start = 1'b0;
        wait_done("t2");
        tick();

        // 3: backpressure on word0
        sign_bits = {$urandom, $urandom};
        push_vec(sign_bits);
        h0 = n_hs;
        m_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("t3");
        for (int i = 0; i < 5; i++) tick();
        m_ready = 1'b1;
        wait_done("t3");
        chk("t3_handshakes", n_hs - h0, 32'd2);
        tick();

        // 4: snapshot isolation
        a = {$urandom, $urandom};
        sign_bits = a;
        push_vec(a);
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 20 && clear_req !== 1'b1; n++) tick();
        chk("t4_capture_seen", {31'b0, clear_req}, 32'd1);
        tick();
        for (int n = 0; n < 20 && done !== 1'b1; n++) begin
            sign_bits = ~sign_bits;
            tick();
        end
        chk("t4_done", {31'b0, done}, 32'd1);
        tick();

        // 5: start ignored outside IDLE and in the DONE cycle
        sign_bits = {$urandom, $urandom};
        push_vec(sign_bits);
        d0 = n_done; c0 = n_clear;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        m_ready = 1'b0;
        wait_valid("t5");
        start = 1'b1; tick(); start = 1'b0;
        m_ready = 1'b1;
        wait_done("t5");
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_start_in_done", {31'b0, busy}, 32'd0);
        chk("t5_single_done", n_done - d0, 32'd1);
        chk("t5_single_clear", n_clear - c0, 32'd1);
        push_vec(sign_bits);
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_restart_busy", {31'b0, busy}, 32'd1);
        wait_done("t5b");
        tick();

        // 6: reset mid-SEND after word0
        sign_bits = {$urandom, $urandom};
        push_vec(sign_bits);
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("t6");
        tick();
        d0 = n_done; c0 = n_clear;
        rst = 1'b1;
        tick();
        chk("t6_valid", {31'b0, m_valid}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_done", {31'b0, done}, 32'd0);
        chk("t6_clear", {31'b0, clear_req}, 32'd0);
        rst = 1'b0;
        chk("t6_flushed_entries", sb_q.size(), 32'd1);
        sb_q.delete();
        tick();
        chk("t6_no_done_pulse", n_done - d0, 32'd0);
        chk("t6_no_clear_pulse", n_clear - c0, 32'd0);
        sign_bits = {$urandom, $urandom};
        push_vec(sign_bits);
        start = 1'b1; tick(); start = 1'b0;
        wait_done("t6");
        tick();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
